// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
  } sw_time_t;

  localparam logic [6:0] CS_MAX    = 7'd99;
  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam sw_time_t   TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_ctrl_tick_sync.sv
// Brings the divider's 1 kHz level into the clk_100MHz domain and turns each
// rising edge into a single-cycle tick. The tick is registered, so it is high
// on the 3rd clk_100MHz posedge after clk_1kHz rises.
module tick_sync (
  input  logic clk_100MHz,
  input  logic rst,
  input  logic clk_1kHz,
  output logic tick
);

  // [0] first sync flop, [1] second sync flop, [2] previous value of [1]
  logic [2:0] sync_q;

  // Two-flop synchronizer, edge-history flop and registered edge pulse.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sync_q <= 3'b000;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], clk_1kHz};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: IDLE/RUNNING/PAUSED/LAP sequencing, cascaded
// prescaler/cs/sec/min counters, lap freeze register and registered display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10,
  parameter int MAX_MIN      = 59
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1kHz,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       div_en,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [6:0] disp_cs,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int         PW        = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_CS - 1);
  localparam logic [5:0] MIN_LAST  = 6'(MAX_MIN);

  sw_state_t     state_q, state_d;
  sw_time_t      live_q, live_d, lap_q, disp_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick, count_en, do_lap, do_clr, wrap, run_d;

  tick_sync u_tick_sync (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .clk_1kHz   (clk_1kHz),
    .tick       (tick)
  );

  // Next-state decode; one transition per cycle, clr > ss > lap.
  always_comb begin
    state_d = state_q;
    do_lap  = 1'b0;
    do_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_clr)     state_d = IDLE;
        else if (btn_ss) state_d = RUNNING;
      end
      RUNNING: begin
        if (btn_ss) state_d = PAUSED;
        else if (btn_lap) begin
          state_d = LAP;
          do_lap  = 1'b1;
        end
      end
      LAP: begin
        if (btn_ss)       state_d = PAUSED;
        else if (btn_lap) state_d = RUNNING;
      end
      PAUSED: begin
        if (btn_clr) begin
          state_d = IDLE;
          do_clr  = 1'b1;
        end else if (btn_ss) begin
          state_d = RUNNING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counting uses the pre-transition state, so a tick coinciding with a stop still counts.
  assign count_en = tick && ((state_q == RUNNING) || (state_q == LAP));
  assign run_d    = (state_d == RUNNING) || (state_d == LAP);

  // Cascaded prescaler -> cs -> sec -> min with wrap detection.
  always_comb begin
    live_d  = live_q;
    presc_d = presc_q;
    wrap    = 1'b0;
    if (do_clr) begin
      live_d  = TIME_ZERO;
      presc_d = '0;
    end else if (count_en) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        if (live_q.cs == CS_MAX) begin
          live_d.cs = 7'd0;
          if (live_q.sec == SEC_MAX) begin
            live_d.sec = 6'd0;
            if (live_q.min == MIN_LAST) begin
              live_d.min = 6'd0;
              wrap       = 1'b1;
            end else begin
              live_d.min = live_q.min + 6'd1;
            end
          end else begin
            live_d.sec = live_q.sec + 6'd1;
          end
        end else begin
          live_d.cs = live_q.cs + 7'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State, counters, lap capture (pre-increment value) and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      live_q     <= TIME_ZERO;
      lap_q      <= TIME_ZERO;
      disp_q     <= TIME_ZERO;
      presc_q    <= '0;
      overflow   <= 1'b0;
      div_en     <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      presc_q    <= presc_d;
      if (do_lap) lap_q <= live_q;
      disp_q     <= (state_q == LAP) ? lap_q : live_q;
      overflow   <= wrap;
      div_en     <= run_d;
      running    <= run_d;
      lap_active <= (state_d == LAP);
    end
  end

  assign disp_min = disp_q.min;
  assign disp_sec = disp_q.sec;
  assign disp_cs  = disp_q.cs;

endmodule
